// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage: ALU function codes (low opcode
// nibble when opcode[5]==0), branch and npc-select opcode prefixes, the stage
// state enum and a small opcode-classification helper.
// ---------------------------------------------------------------------------
package exe_pkg;

    // ALU function select, taken from opcode[3:0] when opcode[5]==0
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SGTU = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;

    // Conditional branches; they differ only in opcode[0]
    localparam logic [5:0] OP_BEQZ = 6'b110100;
    localparam logic [5:0] OP_BNEZ = 6'b110101;

    // opcode[5:1] shared by both branches
    localparam logic [4:0] BR_PFX      = OP_BEQZ[5:1];
    // opcode[5:2] selecting npc instead of register A as operand a
    localparam logic [3:0] NPC_SEL_PFX = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FULL = 2'd2
    } exe_state_e;

    function automatic logic is_mul_op(input logic [5:0] opcode);
        return (opcode[5] == 1'b0) && (opcode[3:0] == OP_MUL);
    endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// ---------------------------------------------------------------------------
// exe_mul_iter
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// Retires MUL_UNROLL multiplier bits per clock, so one product takes
// XLEN/MUL_UNROLL clocks after start.
//
// Ports
//   clk, rst_n     clock / async active-low reset
//   start_i        load operands and begin (ignored while abort_i)
//   abort_i        drop any operation in progress
//   a_i, b_i       multiplicand / multiplier, sampled on start
//   done_o         the coming clock edge retires the last step
//   product_o      product including the current step; valid when done_o
// ---------------------------------------------------------------------------
module exe_mul_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int STEPS = XLEN / MUL_UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_step;
    logic             busy;

    // Partial products for the MUL_UNROLL bits retired this cycle.
    // Only the low XLEN bits are kept, which is all the result needs.
    always_comb begin
        acc_step = acc_q;
        for (int u = 0; u < MUL_UNROLL; u++) begin
            if (mplier_q[u]) begin
                acc_step = acc_step + (mcand_q << u);
            end
        end
    end

    assign busy      = (cnt_q != '0);
    assign done_o    = (cnt_q == CNT_W'(1));
    assign product_o = acc_step;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(STEPS);
        end else if (busy) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << MUL_UNROLL;
            mplier_d = mplier_q >> MUL_UNROLL;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// ---------------------------------------------------------------------------
// exe_stage_mc
// Registered execute stage: operand select, single-cycle ALU, branch
// resolution, iterative multiplier and the EX/MEM output register behind a
// valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock / async active-low reset
//   flush_i                    kill in-flight op and empty the output
//   in_valid / in_ready        ID/EX handshake (in_ready follows out_ready in FULL)
//   a_i, b_i, imm_i, npc_i     register A, register B, immediate, next PC
//   ir_i                       instruction, opcode = ir_i[31:26]
//   out_valid / out_ready      EX/MEM handshake
//   alu_res_o                  result / effective address / branch target
//   b_o                        store data (register B)
//   npc_o                      branch target when taken, else next PC
//   ir_o                       instruction
//   br_taken_o, illegal_o      flags, qualified by out_valid
//
// States
//   state | meaning
//   IDLE  | output register empty, ready for a new op
//   MUL   | multiplier iterating, nothing accepted
//   FULL  | output register holds a result for MEM
// ---------------------------------------------------------------------------
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] npc_i,
    input  logic [31:0]     ir_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_res_o,
    output logic [XLEN-1:0] b_o,
    output logic [XLEN-1:0] npc_o,
    output logic [31:0]     ir_o,
    output logic            br_taken_o,
    output logic            illegal_o
);

    localparam int SH_W = $clog2(XLEN);

    exe_state_e state_q, state_d;

    logic [XLEN-1:0] alu_res_q, alu_res_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic [31:0]     ir_q, ir_d;
    logic            br_taken_q, br_taken_d;
    logic            illegal_q, illegal_d;

    logic [5:0]      opcode;
    logic [XLEN-1:0] op_a, op_b;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            br_taken;
    logic            is_mul;
    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    // ---------------- operand select / ALU / branch ----------------
    assign opcode = ir_i[31:26];
    assign op_a   = (opcode[5:2] == NPC_SEL_PFX) ? npc_i : a_i;
    assign op_b   = opcode[4] ? imm_i : b_i;
    assign shamt  = op_b[SH_W-1:0];
    assign is_mul = is_mul_op(opcode);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        if (opcode[5]) begin
            alu_res = op_a + op_b;
        end else begin
            unique case (opcode[3:0])
                OP_ADD:  alu_res = op_a + op_b;
                OP_SUB:  alu_res = op_a - op_b;
                // product comes from the iterative multiplier instead
                OP_MUL:  alu_res = '0;
                OP_SGTU: alu_res = {{(XLEN-1){1'b0}}, (op_a > op_b)};
                OP_OR:   alu_res = op_a | op_b;
                OP_AND:  alu_res = op_a & op_b;
                OP_XOR:  alu_res = op_a ^ op_b;
                OP_SLL:  alu_res = op_a << shamt;
                OP_SRL:  alu_res = op_a >> shamt;
                default: alu_ill = 1'b1;
            endcase
        end
    end

    // The zero test looks at register A itself, never the npc-selected operand
    assign br_taken = (opcode[5:1] == BR_PFX) && (opcode[0] ^ (a_i == '0));

    // ---------------- multiplier ----------------
    assign mul_start = accept && is_mul;

    exe_mul_iter #(
        .XLEN       (XLEN),
        .MUL_UNROLL (MUL_UNROLL)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (flush_i),
        .a_i       (op_a),
        .b_i       (op_b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = is_mul ? MUL : FULL;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (accept) begin
                            state_d = is_mul ? MUL : FULL;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = !flush_i;
            MUL:     in_ready = 1'b0;
            FULL: begin
                in_ready  = !flush_i && out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
    end

    // ---------------- EX/MEM register ----------------
    // A multiply latches b/ir/npc at acceptance; alu_res is written only
    // when the last multiplier step retires.
    always_comb begin
        alu_res_d  = alu_res_q;
        b_d        = b_q;
        npc_d      = npc_q;
        ir_d       = ir_q;
        br_taken_d = br_taken_q;
        illegal_d  = illegal_q;
        if (!flush_i) begin
            if (accept) begin
                b_d  = b_i;
                ir_d = ir_i;
                if (is_mul) begin
                    npc_d      = npc_i;
                    br_taken_d = 1'b0;
                    illegal_d  = 1'b0;
                end else begin
                    alu_res_d  = alu_res;
                    npc_d      = br_taken ? alu_res : npc_i;
                    br_taken_d = br_taken;
                    illegal_d  = alu_ill;
                end
            end else if ((state_q == MUL) && mul_done) begin
                alu_res_d = mul_prod;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_q  <= '0;
            b_q        <= '0;
            npc_q      <= '0;
            ir_q       <= '0;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            alu_res_q  <= alu_res_d;
            b_q        <= b_d;
            npc_q      <= npc_d;
            ir_q       <= ir_d;
            br_taken_q <= br_taken_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_res_o  = alu_res_q;
    assign b_o        = b_q;
    assign npc_o      = npc_q;
    assign ir_o       = ir_q;
    assign br_taken_o = br_taken_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// ---------------------------------------------------------------------------
// tb_exe_stage_mc
// Two instances (MUL_UNROLL 1 and 4) share one input stream. A transaction
// level model per instance predicts in_ready, out_valid and the output fields.
// ---------------------------------------------------------------------------
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_i, b_i, imm_i, npc_i, ir_i;

    logic        in_ready   [2];
    logic        out_valid  [2];
    logic [31:0] alu_res_o  [2];
    logic [31:0] b_o        [2];
    logic [31:0] npc_o      [2];
    logic [31:0] ir_o       [2];
    logic        br_taken_o [2];
    logic        illegal_o  [2];

    always #5 clk = ~clk;

    exe_stage_mc #(.XLEN(32), .MUL_UNROLL(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .a_i(a_i), .b_i(b_i), .imm_i(imm_i), .npc_i(npc_i), .ir_i(ir_i),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .alu_res_o(alu_res_o[0]), .b_o(b_o[0]), .npc_o(npc_o[0]), .ir_o(ir_o[0]),
        .br_taken_o(br_taken_o[0]), .illegal_o(illegal_o[0])
    );

    exe_stage_mc #(.XLEN(32), .MUL_UNROLL(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .a_i(a_i), .b_i(b_i), .imm_i(imm_i), .npc_i(npc_i), .ir_i(ir_i),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .alu_res_o(alu_res_o[1]), .b_o(b_o[1]), .npc_o(npc_o[1]), .ir_o(ir_o[1]),
        .br_taken_o(br_taken_o[1]), .illegal_o(illegal_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state, one slot per instance
    int          k_lat  [2] = '{32, 8};
    bit          m_full [2];
    int          m_left [2];
    bit          m_acc  [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_b    [2];
    logic [31:0] m_npc  [2];
    logic [31:0] m_ir   [2];
    bit          m_tk   [2];
    bit          m_ill  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of one instruction
    function automatic void ref_exec(input logic [31:0] ra, rb, imm, npc, ir,
                                     output logic [31:0] res, output bit tk,
                                     output bit ill, output bit mul);
        logic [5:0]  opc;
        logic [31:0] a, b;
        opc = ir[31:26];
        a   = (opc[5:2] == 4'b1101) ? npc : ra;
        b   = opc[4] ? imm : rb;
        ill = 0;
        mul = 0;
        res = 0;
        if (opc[5]) begin
            res = a + b;
        end else begin
            case (opc[3:0])
                4'd0: res = a + b;
                4'd1: res = a - b;
                4'd2: begin res = a * b; mul = 1; end
                4'd3: res = (a > b) ? 32'd1 : 32'd0;
                4'd4: res = a | b;
                4'd5: res = a & b;
                4'd6: res = a ^ b;
                4'd7: res = a << b[4:0];
                4'd8: res = a >> b[4:0];
                default: ill = 1;
            endcase
        end
        tk = (opc == 6'b110100 && ra == 0) || (opc == 6'b110101 && ra != 0);
    endfunction

    function automatic bit exp_ready(input int i);
        return !flush_i && m_left[i] == 0 && (!m_full[i] || out_ready);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_left[i] = 0; m_acc[i] = 0;
            m_res[i] = 0; m_pend[i] = 0; m_b[i] = 0; m_npc[i] = 0; m_ir[i] = 0;
            m_tk[i] = 0; m_ill[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] r;
        bit tk, ill, mul;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_full[i] = 0; m_left[i] = 0;
                m_res[i] = 0; m_b[i] = 0; m_npc[i] = 0; m_ir[i] = 0;
                m_tk[i] = 0; m_ill[i] = 0;
            end else if (flush_i) begin
                m_full[i] = 0;
                m_left[i] = 0;
            end else begin
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_full[i] = 1;
                        m_res[i]  = m_pend[i];
                    end
                end else if (m_full[i] && out_ready && !m_acc[i]) begin
                    m_full[i] = 0;
                end
                if (m_acc[i]) begin
                    ref_exec(a_i, b_i, imm_i, npc_i, ir_i, r, tk, ill, mul);
                    m_b[i]  = b_i;
                    m_ir[i] = ir_i;
                    if (mul) begin
                        m_left[i] = k_lat[i];
                        m_full[i] = 0;
                        m_pend[i] = r;
                        m_npc[i]  = npc_i;
                        m_tk[i]   = 0;
                        m_ill[i]  = 0;
                    end else begin
                        m_full[i] = 1;
                        m_res[i]  = r;
                        m_npc[i]  = tk ? r : npc_i;
                        m_tk[i]   = tk;
                        m_ill[i]  = ill;
                    end
                end
            end
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out_valid[%0d]", i), out_valid[i], m_full[i]);
            if (m_full[i]) begin
                chk($sformatf("alu_res[%0d]", i), alu_res_o[i], m_res[i]);
                chk($sformatf("b_o[%0d]", i), b_o[i], m_b[i]);
                chk($sformatf("npc_o[%0d]", i), npc_o[i], m_npc[i]);
                chk($sformatf("ir_o[%0d]", i), ir_o[i], m_ir[i]);
                chk($sformatf("br_taken[%0d]", i), br_taken_o[i], m_tk[i]);
                chk($sformatf("illegal[%0d]", i), illegal_o[i], m_ill[i]);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s out_valid[%0d]", tag, i), out_valid[i], 0);
            chk($sformatf("%s alu_res[%0d]", tag, i), alu_res_o[i], 0);
            chk($sformatf("%s b_o[%0d]", tag, i), b_o[i], 0);
            chk($sformatf("%s npc_o[%0d]", tag, i), npc_o[i], 0);
            chk($sformatf("%s ir_o[%0d]", tag, i), ir_o[i], 0);
            chk($sformatf("%s br_taken[%0d]", tag, i), br_taken_o[i], 0);
            chk($sformatf("%s illegal[%0d]", tag, i), illegal_o[i], 0);
        end
    endtask

    // Called with clk low after inputs are set; returns at the next negedge.
    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), in_ready[i], exp_ready(i));
            m_acc[i] = rst_n && in_valid && exp_ready(i);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic set_op(input logic [5:0] opc, input logic [31:0] a, b, imm, npc);
        ir_i  = {opc, 26'($urandom)};
        a_i   = a;
        b_i   = b;
        imm_i = imm;
        npc_i = npc;
    endtask

    task automatic rand_op();
        logic [5:0] opc;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
                opc = {1'b0, 1'($urandom), 4'($urandom_range(0, 8))};
                if (opc[3:0] == 4'd2 && $urandom_range(0, 3) != 0) opc[3:0] = 4'd6;
            end
            5: opc = {1'b0, 1'($urandom), 4'($urandom_range(9, 15))};
            6: opc = 6'h23;
            7: opc = {1'b1, 5'($urandom)};
            8: opc = 6'b110100;
            default: opc = 6'b110101;
        endcase
        set_op(opc,
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
               ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
               $urandom, $urandom);
    endtask

    int lat [2];
    logic [31:0] cap [2];

    initial begin
        rst_n = 1; flush_i = 0; in_valid = 0; out_ready = 1;
        set_op(6'h00, 0, 0, 0, 0);
        model_reset();
        #1 rst_n = 0;
        @(negedge clk);
        check_zero("reset");
        cycle();
        rst_n = 1;
        cycle();

        // ADD then back-to-back SUB
        in_valid = 1; out_ready = 1;
        set_op(6'h00, 7, 5, 0, 32'h40);
        cycle();
        chk("add res", alu_res_o[0], 12);
        chk("add ill", illegal_o[0], 0);
        chk("add tk", br_taken_o[0], 0);
        set_op(6'h01, 5, 7, 0, 32'h44);
        cycle();
        chk("sub res", alu_res_o[0], 32'hFFFF_FFFE);
        chk("sub valid", out_valid[0], 1);
        in_valid = 0;
        cycle();

        // MUL latency on both unroll settings
        in_valid = 1;
        set_op(6'h02, 32'h0001_0000, 32'h0003_0001, 0, 32'h80);
        cycle();
        in_valid = 0;
        lat = '{-1, -1};
        cap = '{0, 0};
        for (int j = 1; j <= 40; j++) begin
            cycle();
            for (int i = 0; i < 2; i++)
                if (out_valid[i] && lat[i] < 0) begin
                    lat[i] = j;
                    cap[i] = alu_res_o[i];
                end
        end
        chk("mul lat u1", 32'(lat[0]), 32);
        chk("mul lat u4", 32'(lat[1]), 8);
        chk("mul res u1", cap[0], 32'h0001_0000);
        chk("mul res u4", cap[1], 32'h0001_0000);

        // branches
        in_valid = 1;
        set_op(6'b110100, 0, 32'h55, 32'h20, 32'h100);
        cycle();
        chk("beqz tk", br_taken_o[0], 1);
        chk("beqz npc", npc_o[0], 32'h120);
        set_op(6'b110101, 0, 32'h55, 32'h20, 32'h100);
        cycle();
        chk("bnez tk", br_taken_o[0], 0);
        chk("bnez npc", npc_o[0], 32'h100);

        // illegal op and unsigned compare
        set_op(6'b001001, 3, 4, 0, 0);
        cycle();
        chk("illegal res", alu_res_o[0], 0);
        chk("illegal flag", illegal_o[0], 1);
        set_op(6'h03, 1, 32'hFFFF_FFFF, 0, 0);
        cycle();
        chk("sgtu res", alu_res_o[0], 0);
        in_valid = 0;
        cycle();

        // backpressure hold
        out_ready = 0; in_valid = 1;
        set_op(6'h00, 3, 4, 0, 0);
        cycle();
        chk("hold first", alu_res_o[0], 7);
        cap[0] = ir_o[0];
        set_op(6'h06, 32'hF0, 32'hFF, 0, 0);
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("hold in_ready", in_ready[0], 0);
            chk("hold res", alu_res_o[0], 7);
            chk("hold ir", ir_o[0], cap[0]);
        end
        out_ready = 1;
        #1 chk("release in_ready", in_ready[0], 1);
        cycle();
        chk("release res", alu_res_o[0], 32'h0F);
        in_valid = 0;
        cycle();

        // flush during MUL
        in_valid = 1;
        set_op(6'h02, 6, 7, 0, 0);
        cycle();
        in_valid = 0;
        for (int j = 0; j < 9; j++) cycle();
        flush_i = 1;
        cycle();
        flush_i = 0;
        chk("flush valid", out_valid[0], 0);
        for (int j = 0; j < 30; j++) cycle();
        in_valid = 1;
        set_op(6'h00, 1, 2, 0, 0);
        cycle();
        chk("after flush", alu_res_o[0], 3);
        in_valid = 0;

        // async reset mid-MUL
        in_valid = 1;
        set_op(6'h12, 32'h1234, 0, 32'h55, 0);
        cycle();
        in_valid = 0;
        for (int j = 0; j < 10; j++) cycle();
        #2 rst_n = 0;
        #1 check_zero("async rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !m_acc[0])) begin
                in_valid = ($urandom_range(0, 9) < 7);
                rand_op();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush_i   = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush_i = 0;
        in_valid = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
